hartslag_meter: RTL and testbench

Upstream input stage that turns the raw heartbeat pulse line into an 8-bit beats-per-minute value for the rocking controller. It debounces and times the pulse, averages the last four beat intervals, and divides to BPM with an iterative divider. It flags a high heart rate and a missing heartbeat. It runs on the fast system clock beside the crying-level input stage.

---
 rtl/hartslag_meter_if.sv | 24 ++
 rtl/hartslag_meter.sv | 195 +++++++++++++++++++
 tb/tb_hartslag_meter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hartslag_meter_if.sv
// Heartbeat meter connection bundle: raw pulse input plus the BPM result and status flags.
interface hartslag_meter_if;
  logic       hartslagIngang;
  logic [7:0] hartslag;
  logic       hartslagValid;
  logic       hartslagHoog;
  logic       hartslagFout;

  modport master (
    input  hartslagIngang,
    output hartslag,
    output hartslagValid,
    output hartslagHoog,
    output hartslagFout
  );

  modport slave (
    output hartslagIngang,
    input  hartslag,
    input  hartslagValid,
    input  hartslagHoog,
    input  hartslagFout
  );
endinterface

// File: rtl/hartslag_meter.sv
// Heartbeat pulse to BPM: synchronise, time intervals in ms, average the last four
// intervals and divide 240000 by their sum with a bit-serial restoring divider.
module hartslag_meter #(
  parameter int TICK_DIV   = 50000,
  parameter int REFRACT_MS = 240,
  parameter int TIMEOUT_MS = 3000,
  parameter int HOOG_BPM   = 140
) (
  input  logic             clk,
  input  logic             reset,
  hartslag_meter_if.master hs
);

  typedef enum logic [1:0] {ZOEK, METEN, DELEN, FOUT} state_t;

  localparam int            PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LP_PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [11:0]   LP_REFRACT  = 12'(REFRACT_MS);
  localparam logic [11:0]   LP_TIMEOUT  = 12'(TIMEOUT_MS);
  localparam logic [7:0]    LP_HOOG     = 8'(HOOG_BPM);
  localparam logic [17:0]   LP_DIVIDEND = 18'd240000;

  state_t r_state, w_state_nx;

  logic          r_sync1, r_sync2, r_prev, r_edge;
  logic [PW-1:0] r_pre;
  logic          w_tick;
  logic [11:0]   r_ms;
  logic [11:0]   r_h0, r_h1, r_h2, r_h3;
  logic [2:0]    r_nhist;
  logic [13:0]   w_sum;
  logic          w_ms_ok;

  logic          w_clr_ms, w_shift, w_start, w_done, w_enter_fout;

  logic [13:0]   r_rem;
  logic [17:0]   r_dvd;
  logic [16:0]   r_q;
  logic [4:0]    r_it;
  logic [14:0]   w_rem_sh;
  logic          w_ge;
  logic [13:0]   w_rem_nx;
  logic [17:0]   w_q_nx;
  logic [7:0]    w_q_sat;

  logic [7:0]    r_bpm;
  logic          r_valid, r_hoog, r_fout;

  // Input synchroniser and registered rising-edge detector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= hs.hartslagIngang;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_edge  <= r_sync2 & ~r_prev;
    end
  end

  assign w_tick  = (r_pre == LP_PRE_MAX);
  assign w_ms_ok = (r_ms >= LP_REFRACT);
  assign w_sum   = 14'(r_h0) + 14'(r_h1) + 14'(r_h2) + 14'(r_h3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ZOEK;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_clr_ms     = 1'b0;
    w_shift      = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_enter_fout = 1'b0;
    unique case (r_state)
      ZOEK: begin
        if (r_edge) begin
          w_clr_ms   = 1'b1;
          w_state_nx = METEN;
        end else if (r_ms == LP_TIMEOUT) begin
          w_enter_fout = 1'b1;
          w_state_nx   = FOUT;
        end
      end
      METEN: begin
        if (r_edge && w_ms_ok) begin
          w_clr_ms = 1'b1;
          w_shift  = 1'b1;
          if (r_nhist >= 3'd3) begin
            w_start    = 1'b1;
            w_state_nx = DELEN;
          end
        end else if (r_ms == LP_TIMEOUT) begin
          w_enter_fout = 1'b1;
          w_state_nx   = FOUT;
        end
      end
      DELEN: begin
        if (r_it == 5'd17) begin
          w_done     = 1'b1;
          w_state_nx = METEN;
        end
      end
      FOUT: begin
        if (r_edge) begin
          w_clr_ms   = 1'b1;
          w_state_nx = METEN;
        end
      end
      default: w_state_nx = ZOEK;
    endcase
  end

  // One restoring-division step; the last step's quotient feeds the output directly
  assign w_rem_sh = {r_rem, r_dvd[17]};
  assign w_ge     = (w_rem_sh >= {1'b0, w_sum});
  assign w_rem_nx = w_ge ? 14'(w_rem_sh - {1'b0, w_sum}) : w_rem_sh[13:0];
  assign w_q_nx   = {r_q, w_ge};
  assign w_q_sat  = (|w_q_nx[17:8]) ? 8'hFF : w_q_nx[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre   <= '0;
      r_ms    <= '0;
      r_h0    <= '0;
      r_h1    <= '0;
      r_h2    <= '0;
      r_h3    <= '0;
      r_nhist <= '0;
      r_rem   <= '0;
      r_dvd   <= '0;
      r_q     <= '0;
      r_it    <= '0;
      r_bpm   <= '0;
      r_valid <= 1'b0;
      r_hoog  <= 1'b0;
      r_fout  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_pre   <= w_tick ? '0 : r_pre + PW'(1);

      if (w_clr_ms)
        r_ms <= '0;
      else if (w_tick && (r_ms != LP_TIMEOUT))
        r_ms <= r_ms + 12'd1;

      if (w_enter_fout) begin
        r_h0    <= '0;
        r_h1    <= '0;
        r_h2    <= '0;
        r_h3    <= '0;
        r_nhist <= '0;
        r_bpm   <= '0;
        r_hoog  <= 1'b0;
        r_fout  <= 1'b1;
      end else if (w_shift) begin
        r_h0 <= r_ms;
        r_h1 <= r_h0;
        r_h2 <= r_h1;
        r_h3 <= r_h2;
        if (r_nhist != 3'd4) r_nhist <= r_nhist + 3'd1;
      end

      if (w_start) begin
        r_rem <= '0;
        r_dvd <= LP_DIVIDEND;
        r_q   <= '0;
        r_it  <= '0;
      end else if (r_state == DELEN) begin
        r_rem <= w_rem_nx;
        r_dvd <= {r_dvd[16:0], 1'b0};
        r_q   <= w_q_nx[16:0];
        r_it  <= r_it + 5'd1;
      end

      if (w_done) begin
        r_bpm   <= w_q_sat;
        r_hoog  <= (w_q_sat > LP_HOOG);
        r_fout  <= 1'b0;
        r_valid <= 1'b1;
      end
    end
  end

  assign hs.hartslag      = r_bpm;
  assign hs.hartslagValid = r_valid;
  assign hs.hartslagHoog  = r_hoog;
  assign hs.hartslagFout  = r_fout;

endmodule

// File: tb/tb_hartslag_meter.sv
// Scoreboard bench for hartslag_meter: a millisecond-level beat model predicts each BPM result.
module tb_hartslag_meter;
  localparam int TD   = 3;
  localparam int REFR = 200;
  localparam int TMO  = 3000;
  localparam int HOOG = 140;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hartslag_meter_if hs_if ();

  hartslag_meter #(
    .TICK_DIV  (TD),
    .REFRACT_MS(REFR),
    .TIMEOUT_MS(TMO),
    .HOOG_BPM  (HOOG)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hs   (hs_if)
  );

  int pcnt;
  always @(posedge clk) begin
    if (!reset) pcnt <= 0;
    else        pcnt <= pcnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, want, pcnt);
    end
  endtask

  typedef struct {
    int bpm;
    int hoog;
    int when;
  } exp_t;
  exp_t sbq[$];

  // Model: last four accepted intervals in ms; the first edge after reset/fault only starts timing
  int hist[$];
  bit searching = 1'b1;
  int t_acc = 0;

  task automatic model_edge(input int gap_ms, input int t_raise, input bit suppress);
    int   sum;
    int   q;
    exp_t e;
    if (searching) begin
      searching = 1'b0;
      t_acc     = t_raise;
    end else if (gap_ms >= REFR) begin
      hist.push_front(gap_ms);
      if (hist.size() > 4) void'(hist.pop_back());
      t_acc = t_raise;
      if (hist.size() == 4 && !suppress) begin
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        q = 240000 / sum;
        if (q > 255) q = 255;
        e.bpm  = q;
        e.hoog = (q > HOOG) ? 1 : 0;
        e.when = t_raise + 22;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic start_search();
    do @(negedge clk); while ((pcnt % TD) != 0);
    t_acc = pcnt;
  endtask

  task automatic pulse(input int gap_ms, input bit suppress = 1'b0);
    int t;
    t = t_acc + gap_ms * TD;
    if (pcnt > t) check("pulse_schedule", pcnt, t);
    while (pcnt < t) @(negedge clk);
    hs_if.hartslagIngang = 1'b1;
    model_edge(gap_ms, t, suppress);
    @(negedge clk);
    hs_if.hartslagIngang = 1'b0;
  endtask

  task automatic expect_fault();
    int lim;
    lim = t_acc + TMO * TD + 4;
    while (!hs_if.hartslagFout && pcnt < lim + 50) @(negedge clk);
    check("fout_rise", int'(hs_if.hartslagFout), 1);
    check("fout_time", pcnt, lim);
    check("fout_bpm", int'(hs_if.hartslag), 0);
    check("fout_hoog", int'(hs_if.hartslagHoog), 0);
    hist.delete();
    searching = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset && hs_if.hartslagValid) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("bpm", int'(hs_if.hartslag), e.bpm);
        check("hoog", int'(hs_if.hartslagHoog), e.hoog);
        check("fout_on_valid", int'(hs_if.hartslagFout), 0);
        check("valid_cycle", pcnt, e.when);
      end
    end
  end

  initial begin
    hs_if.hartslagIngang = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_bpm", int'(hs_if.hartslag), 0);
    check("rst_valid", int'(hs_if.hartslagValid), 0);
    check("rst_hoog", int'(hs_if.hartslagHoog), 0);
    check("rst_fout", int'(hs_if.hartslagFout), 0);
    reset = 1'b1;

    // 800 ms train -> 75, then 400 ms -> 85/100/120/150
    start_search();
    pulse(50);
    repeat (4) pulse(800);
    repeat (4) pulse(400);

    // 500 ms train with refractory glitches
    pulse(500);
    pulse(100);
    repeat (3) pulse(500);
    pulse(100);
    pulse(500);

    // Timeout, then recovery at 600 ms
    expect_fault();
    start_search();
    pulse(10);
    repeat (10) @(negedge clk);
    check("fout_hold_after_edge", int'(hs_if.hartslagFout), 1);
    check("bpm_zero_in_fault", int'(hs_if.hartslag), 0);
    repeat (4) pulse(600);

    // Refractory boundary and saturation
    pulse(REFR - 1);
    repeat (4) pulse(REFR);

    repeat (6) begin
      if ($urandom_range(0, 2) == 0) pulse(int'($urandom_range(20, REFR - 1)));
      pulse(int'($urandom_range(REFR, 700)));
    end

    // Reset during division
    pulse(300);
    pulse(300, 1'b1);
    while (pcnt < t_acc + 13) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_bpm", int'(hs_if.hartslag), 0);
    check("midrst_valid", int'(hs_if.hartslagValid), 0);
    check("midrst_hoog", int'(hs_if.hartslagHoog), 0);
    check("midrst_fout", int'(hs_if.hartslagFout), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    hist.delete();
    searching = 1'b1;
    repeat (100 * TD) @(negedge clk);
    check("idle_fout", int'(hs_if.hartslagFout), 0);
    check("idle_bpm", int'(hs_if.hartslag), 0);
    start_search();
    pulse(10);
    repeat (4) pulse(250);

    repeat (40) @(negedge clk);
    check("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
